// File: rtl/score_keeper.sv
// score_keeper: game-state bookkeeper feeding the HUD renderer.
//
// Turns one-cycle game events into a saturating score, a lives count with
// bonus lives, a post-hit invulnerability window and a game-over flag.
// All outputs come straight from registers and change one edge after the
// event that caused them.
//
// Ports:
//   clk         in   1   system clock
//   rst         in   1   synchronous, active-high reset
//   new_game    in   1   pulse: start or restart a game
//   frame_tick  in   1   pulse once per video frame
//   alien_hit   in   1   pulse: alien destroyed
//   alien_type  in   2   point class of the alien, valid with alien_hit
//   player_hit  in   1   pulse: player ship struck
//   score       out  14  current score, 0..9999
//   lives       out  2   current lives, 0..3
//   game_over   out  1   high while in the game-over state
//   invuln      out  1   high while the player is invulnerable
//   life_lost   out  1   pulse when a hit removes a life
//   extra_life  out  1   pulse when a bonus life is granted

module score_keeper #(
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned MAX_LIVES        = 3,
    parameter int unsigned EXTRA_LIFE_EVERY = 1000,
    parameter int unsigned INVULN_FRAMES    = 120,
    parameter int unsigned PTS_0            = 10,
    parameter int unsigned PTS_1            = 20,
    parameter int unsigned PTS_2            = 30,
    parameter int unsigned PTS_3            = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        frame_tick,
    input  logic        alien_hit,
    input  logic [1:0]  alien_type,
    input  logic        player_hit,
    output logic [13:0] score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        invuln,
    output logic        life_lost,
    output logic        extra_life
);

    localparam logic [14:0] SCORE_MAX   = 15'd9999;
    localparam logic [14:0] BONUS_STEP  = 15'(EXTRA_LIFE_EVERY);
    localparam logic [1:0]  LIVES_START = 2'(START_LIVES);
    localparam logic [1:0]  LIVES_MAX   = 2'(MAX_LIVES);
    localparam logic [7:0]  INVULN_LOAD = 8'(INVULN_FRAMES);
    localparam bit          BONUS_ON    = (EXTRA_LIFE_EVERY != 0);

    typedef enum logic [1:0] {StIdle, StPlay, StInvuln, StOver} state_e;

    state_e      state_q, state_d;
    logic [13:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [14:0] next_bonus_q, next_bonus_d;
    logic [7:0]  invuln_cnt_q, invuln_cnt_d;
    logic        life_lost_q, life_lost_d;
    logic        extra_life_q, extra_life_d;

    logic [14:0] pts;
    logic [14:0] score_sum;
    logic [14:0] score_new;
    logic        scoring;
    logic        bonus;
    logic [1:0]  lives_bonus;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            score_q      <= '0;
            lives_q      <= '0;
            next_bonus_q <= BONUS_STEP;
            invuln_cnt_q <= '0;
            life_lost_q  <= 1'b0;
            extra_life_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            next_bonus_q <= next_bonus_d;
            invuln_cnt_q <= invuln_cnt_d;
            life_lost_q  <= life_lost_d;
            extra_life_q <= extra_life_d;
        end
    end

    always_comb begin
        pts = '0;
        unique case (alien_type)
            2'd0: pts = 15'(PTS_0);
            2'd1: pts = 15'(PTS_1);
            2'd2: pts = 15'(PTS_2);
            2'd3: pts = 15'(PTS_3);
            default: pts = '0;
        endcase
    end

    // Sum in 15 bits so an overflow past 9999 is visible before clamping.
    assign score_sum = {1'b0, score_q} + pts;
    assign score_new = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;
    assign scoring   = alien_hit && ((state_q == StPlay) || (state_q == StInvuln));
    assign bonus     = BONUS_ON && scoring && (next_bonus_q <= SCORE_MAX) &&
                       (score_new >= next_bonus_q);

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        next_bonus_d = next_bonus_q;
        invuln_cnt_d = invuln_cnt_q;
        life_lost_d  = 1'b0;
        extra_life_d = 1'b0;
        lives_bonus  = lives_q;

        if (new_game) begin
            // Same-cycle alien_hit / player_hit are dropped.
            state_d      = StPlay;
            score_d      = '0;
            lives_d      = LIVES_START;
            next_bonus_d = BONUS_STEP;
            invuln_cnt_d = '0;
        end else begin
            if (scoring) begin
                score_d = score_new[13:0];
            end
            // Threshold advances even when the lives cap blocks the award.
            if (bonus) begin
                next_bonus_d = next_bonus_q + BONUS_STEP;
                if (lives_q < LIVES_MAX) begin
                    lives_bonus  = lives_q + 2'd1;
                    extra_life_d = 1'b1;
                end
            end
            lives_d = lives_bonus;

            unique case (state_q)
                StPlay: begin
                    // Bonus from this cycle counts before the hit is applied.
                    if (player_hit) begin
                        life_lost_d = 1'b1;
                        lives_d     = lives_bonus - 2'd1;
                        if (lives_d == 2'd0) begin
                            state_d      = StOver;
                            invuln_cnt_d = '0;
                        end else begin
                            state_d      = StInvuln;
                            invuln_cnt_d = INVULN_LOAD;
                        end
                    end
                end
                StInvuln: begin
                    if (frame_tick) begin
                        if (invuln_cnt_q <= 8'd1) begin
                            invuln_cnt_d = '0;
                            state_d      = StPlay;
                        end else begin
                            invuln_cnt_d = invuln_cnt_q - 8'd1;
                        end
                    end
                end
                StOver: invuln_cnt_d = '0;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        score      = score_q;
        lives      = lives_q;
        game_over  = (state_q == StOver);
        invuln     = (state_q == StInvuln);
        life_lost  = life_lost_q;
        extra_life = extra_life_q;
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed-vector self-checking bench for score_keeper.

module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        frame_tick;
    logic        alien_hit;
    logic [1:0]  alien_type;
    logic        player_hit;
    logic [13:0] score;
    logic [1:0]  lives;
    logic        game_over;
    logic        invuln;
    logic        life_lost;
    logic        extra_life;

    int n_checks = 0;
    int n_fail   = 0;
    int xl_count = 0;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .frame_tick (frame_tick),
        .alien_hit  (alien_hit),
        .alien_type (alien_type),
        .player_hit (player_hit),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over),
        .invuln     (invuln),
        .life_lost  (life_lost),
        .extra_life (extra_life)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic pulse(input logic ng, input logic ah, input logic [1:0] at,
                         input logic ph, input logic ft);
        new_game   = ng;
        alien_hit  = ah;
        alien_type = at;
        player_hit = ph;
        frame_tick = ft;
        @(posedge clk);
        #1;
        new_game   = 1'b0;
        alien_hit  = 1'b0;
        alien_type = 2'd0;
        player_hit = 1'b0;
        frame_tick = 1'b0;
        xl_count  += int'(extra_life);
    endtask

    task automatic aliens(input int n, input logic [1:0] at);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, at, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        new_game   = 1'b0;
        frame_tick = 1'b0;
        alien_hit  = 1'b0;
        alien_type = 2'd0;
        player_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_score", score, 0);
        check_eq("rst_lives", lives, 0);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_invuln", invuln, 0);
        check_eq("rst_life_lost", life_lost, 0);
        check_eq("rst_extra_life", extra_life, 0);
        rst = 1'b0;

        // Events in IDLE are ignored
        pulse(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        check_eq("idle_score", score, 0);
        check_eq("idle_life_lost", life_lost, 0);

        // New game
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check_eq("ng_score", score, 0);
        check_eq("ng_lives", lives, 3);
        check_eq("ng_game_over", game_over, 0);
        check_eq("ng_invuln", invuln, 0);

        // Bonus thresholds at 1000/2000/3000 are all capped
        xl_count = 0;
        aliens(33, 2'd3);
        check_eq("a33_score", score, 3300);
        check_eq("a33_lives", lives, 3);
        check_eq("a33_no_extra", xl_count, 0);

        // Hit in PLAY
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("hit1_lives", lives, 2);
        check_eq("hit1_life_lost", life_lost, 1);
        check_eq("hit1_invuln", invuln, 1);
        pulse(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check_eq("hit1_life_lost_pulse", life_lost, 0);
        // Second hit during invulnerability is ignored
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("hit2_lives", lives, 2);
        check_eq("hit2_life_lost", life_lost, 0);

        // Scoring in INVULN; next threshold is 4000, lives below cap now
        xl_count = 0;
        aliens(7, 2'd3);
        check_eq("a7_score", score, 4000);
        check_eq("a7_lives", lives, 3);
        check_eq("a7_extra_count", xl_count, 1);
        check_eq("a7_extra_now", extra_life, 1);
        pulse(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check_eq("a7_extra_pulse", extra_life, 0);

        ticks(119);
        check_eq("inv_119", invuln, 1);
        ticks(1);
        check_eq("inv_120", invuln, 0);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("hit3_lives", lives, 2);
        check_eq("hit3_invuln", invuln, 1);

        // Scenario B: down to one life, combined score+hit
        pulse(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("b_hit1_lives", lives, 2);
        ticks(120);
        check_eq("b_inv_end1", invuln, 0);
        // frame_tick with the entering hit must not count
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        check_eq("b_hit2_lives", lives, 1);
        ticks(119);
        check_eq("b_inv_119", invuln, 1);
        ticks(1);
        check_eq("b_inv_120", invuln, 0);
        xl_count = 0;
        aliens(9, 2'd3);
        aliens(3, 2'd2);
        check_eq("b_score_990", score, 990);
        check_eq("b_no_extra", xl_count, 0);
        pulse(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        check_eq("b_combo_score", score, 1010);
        check_eq("b_combo_extra", extra_life, 1);
        check_eq("b_combo_life_lost", life_lost, 1);
        check_eq("b_combo_lives", lives, 1);
        check_eq("b_combo_invuln", invuln, 1);
        check_eq("b_combo_game_over", game_over, 0);
        ticks(120);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("b_fatal_lives", lives, 0);
        check_eq("b_fatal_game_over", game_over, 1);
        check_eq("b_fatal_life_lost", life_lost, 1);
        check_eq("b_fatal_invuln", invuln, 0);
        aliens(1, 2'd3);
        check_eq("over_score_frozen", score, 1010);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("over_hit_ignored", life_lost, 0);
        check_eq("over_lives", lives, 0);
        // new_game overrides same-cycle events
        pulse(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
        check_eq("ng2_score", score, 0);
        check_eq("ng2_lives", lives, 3);
        check_eq("ng2_game_over", game_over, 0);
        check_eq("ng2_life_lost", life_lost, 0);
        check_eq("ng2_invuln", invuln, 0);

        // Scenario C: saturation; next threshold 10000 is unreachable
        aliens(99, 2'd3);
        aliens(3, 2'd2);
        check_eq("c_score_9990", score, 9990);
        pulse(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check_eq("c_hit_lives", lives, 2);
        xl_count = 0;
        aliens(1, 2'd3);
        check_eq("c_sat1", score, 9999);
        aliens(1, 2'd3);
        check_eq("c_sat2", score, 9999);
        check_eq("c_no_extra", xl_count, 0);
        check_eq("c_lives_kept", lives, 2);

        // Scenario D: reset mid-PLAY wins over same-cycle events
        ticks(120);
        check_eq("d_play", invuln, 0);
        rst = 1'b1;
        pulse(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        rst = 1'b0;
        check_eq("d_rst_score", score, 0);
        check_eq("d_rst_lives", lives, 0);
        check_eq("d_rst_game_over", game_over, 0);
        check_eq("d_rst_invuln", invuln, 0);
        check_eq("d_rst_life_lost", life_lost, 0);
        check_eq("d_rst_extra_life", extra_life, 0);
        aliens(1, 2'd3);
        check_eq("d_idle_score", score, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
